cache_miss_handler: RTL and testbench



---
 rtl/cache_pkg.sv | 20 ++
 rtl/sat_counter.sv | 20 ++
 rtl/cache_miss_handler.sv | 107 ++++++++++
 tb/tb_cache_miss_handler.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and default widths for the cache and its miss handler.
package cache_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned LINE_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [LINE_W_DEF-1:0] val_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    CHECK,
    FETCH,
    FILL,
    RESPOND
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, stop at all-ones, clear has priority.
  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_miss_handler.sv
// Read-miss handler: looks up the cache, fetches from memory on a miss,
// fills the cache line, then returns the line to the client.
module cache_miss_handler
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_W_DEF,
  parameter int unsigned LINE_WIDTH = LINE_W_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [LINE_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] ch1_in_addr,
  output logic [LINE_WIDTH-1:0] ch1_in_val,
  output logic                  ch1_read,
  output logic                  ch1_write,
  input  logic                  ch1_hit,
  input  logic [LINE_WIDTH-1:0] ch1_out_val,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] data_q;
  logic [LINE_WIDTH-1:0] rsp_data_q;
  // High only in the first FILL cycle, whose ch1_hit is left over from before the write.
  logic                  fill_first_q;
  logic                  hit_inc, miss_inc;

  // State register plus the address/data capture registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      rsp_data_q   <= '0;
      fill_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_first_q <= (state_q == FETCH) && mem_ack;
      if ((state_q == IDLE) && req_valid) begin
        addr_q <= req_addr;
      end
      if ((state_q == CHECK) && ch1_hit) begin
        rsp_data_q <= ch1_out_val;
      end
      if ((state_q == FETCH) && mem_ack) begin
        data_q     <= mem_rdata;
        rsp_data_q <= mem_rdata;
      end
    end
  end

  // Next-state logic; mem_ack only matters while in FETCH.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = LOOKUP;
      LOOKUP:  state_d = CHECK;
      CHECK:   state_d = ch1_hit ? RESPOND : FETCH;
      FETCH:   if (mem_ack) state_d = FILL;
      FILL:    if (!fill_first_q && ch1_hit) state_d = RESPOND;
      RESPOND: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore strobes decoded from state.
  always_comb begin
    req_ready   = (state_q == IDLE);
    ch1_read    = (state_q == LOOKUP);
    ch1_write   = (state_q == FILL);
    mem_req     = (state_q == FETCH);
    rsp_valid   = (state_q == RESPOND);
    ch1_in_addr = addr_q;
    mem_addr    = addr_q;
    ch1_in_val  = (state_q == FILL) ? data_q : '0;
    rsp_data    = rsp_data_q;
    hit_inc     = (state_q == CHECK) && ch1_hit;
    miss_inc    = (state_q == CHECK) && !ch1_hit;
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clock (clock),
    .clear (!reset_n),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clock (clock),
    .clear (!reset_n),
    .inc   (miss_inc),
    .count (miss_count)
  );

endmodule

// File: tb/tb_cache_miss_handler.sv
// Directed bench for cache_miss_handler with a two-entry clock-replacement cache model.
module tb_cache_miss_handler;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [7:0]  ch1_in_addr;
  logic [31:0] ch1_in_val;
  logic        ch1_read, ch1_write;
  logic        ch1_hit = 1'b0;
  logic [31:0] ch1_out_val = '0;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  hit_count, miss_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  cache_miss_handler #(.ADDR_WIDTH(8), .LINE_WIDTH(32), .CNT_WIDTH(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .ch1_in_addr(ch1_in_addr), .ch1_in_val(ch1_in_val),
    .ch1_read(ch1_read), .ch1_write(ch1_write),
    .ch1_hit(ch1_hit), .ch1_out_val(ch1_out_val),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // Cache model: registered results; a write into a full cache first sweeps clock bits.
  logic        cv   [2];
  logic [7:0]  ctag [2];
  logic [31:0] cdat [2];
  logic        cbit [2];
  int          ptr = 0;
  int          fills = 0;
  int          m_idx, m_free;

  initial begin
    for (int i = 0; i < 2; i++) begin
      cv[i] = 1'b0; ctag[i] = '0; cdat[i] = '0; cbit[i] = 1'b0;
    end
  end

  always @(posedge clock) begin
    m_idx = -1;
    for (int i = 0; i < 2; i++) if (cv[i] && ctag[i] == ch1_in_addr) m_idx = i;
    if (ch1_read) begin
      if (m_idx >= 0) begin
        cbit[m_idx] = 1'b1;
        ch1_hit     <= 1'b1;
        ch1_out_val <= cdat[m_idx];
      end else begin
        ch1_hit     <= 1'b0;
        ch1_out_val <= '0;
      end
    end else if (ch1_write) begin
      if (m_idx >= 0) begin
        cdat[m_idx] = ch1_in_val;
        ch1_hit <= 1'b1;
      end else begin
        m_free = -1;
        for (int i = 0; i < 2; i++) if (!cv[i] && m_free < 0) m_free = i;
        if (m_free >= 0) begin
          cv[m_free] = 1'b1; ctag[m_free] = ch1_in_addr;
          cdat[m_free] = ch1_in_val; cbit[m_free] = 1'b1;
          fills++;
          ch1_hit <= 1'b1;
        end else if (cbit[ptr]) begin
          cbit[ptr] = 1'b0;
          ptr = (ptr + 1) % 2;
          ch1_hit <= 1'b0;
        end else begin
          ctag[ptr] = ch1_in_addr; cdat[ptr] = ch1_in_val; cbit[ptr] = 1'b1;
          ptr = (ptr + 1) % 2;
          fills++;
          ch1_hit <= 1'b1;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Issue one request and act as memory; returns when rsp_valid rises or the budget expires.
  task automatic run_req(input logic [7:0] addr, input int ack_delay, input logic [31:0] mdata,
                         output int lat, output int fill_cyc, output int mreq_cyc,
                         output int clash, output int ival_bad, output bit timeout);
    lat = 0; fill_cyc = 0; mreq_cyc = 0; clash = 0; ival_bad = 0; timeout = 0;
    req_valid = 1'b1;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
    while (!rsp_valid) begin
      if (lat >= 60) begin
        timeout = 1;
        break;
      end
      if (ch1_read && ch1_write) clash++;
      if (ch1_write) fill_cyc++;
      if (!ch1_write && ch1_in_val !== 32'h0) ival_bad++;
      if (mem_req) begin
        mreq_cyc++;
        mem_ack   = (mreq_cyc == ack_delay);
        mem_rdata = mdata;
      end else begin
        mem_ack = 1'b0;
      end
      tick();
      lat++;
    end
    mem_ack = 1'b0;
  endtask

  task automatic release_rsp;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if ({rsp_valid, mem_req, ch1_read, ch1_write} !== 4'b0) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", {rsp_valid, mem_req, ch1_read, ch1_write}); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
    checks++; if ({hit_count, miss_count} !== 4'b0) begin errors++; $display("FAIL reset_counts: got %b expected 0000", {hit_count, miss_count}); end
    checks++; if (ch1_in_val !== 32'h0) begin errors++; $display("FAIL reset_in_val: got %h expected 0", ch1_in_val); end
  endtask

  task automatic test_hit;
    int lat, fc, mc, cl, ib; bit to;
    cv[0] = 1'b1; ctag[0] = 8'h12; cdat[0] = 32'hDEADBEEF; cbit[0] = 1'b0;
    run_req(8'h12, 1, 32'h0, lat, fc, mc, cl, ib, to);
    checks++; if (to || lat != 2) begin errors++; $display("FAIL hit_latency: got %0d (timeout %0d) expected 2", lat, to); end
    checks++; if (rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL hit_data: got %h expected deadbeef", rsp_data); end
    checks++; if (mc != 0) begin errors++; $display("FAIL hit_mem_req: got %0d cycles expected 0", mc); end
    checks++; if (hit_count !== 2'd1 || miss_count !== 2'd0) begin errors++; $display("FAIL hit_counts: got %0d/%0d expected 1/0", hit_count, miss_count); end
    release_rsp();
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL hit_back_idle: got ready %b valid %b expected 1 0", req_ready, rsp_valid); end
  endtask

  task automatic test_miss;
    int lat, fc, mc, cl, ib, f0; bit to;
    f0 = fills;
    run_req(8'h40, 5, 32'hCAFEF00D, lat, fc, mc, cl, ib, to);
    checks++; if (to) begin errors++; $display("FAIL miss_timeout: got timeout after %0d cycles expected response", lat); end
    checks++; if (mc != 5) begin errors++; $display("FAIL miss_mem_req_cycles: got %0d expected 5", mc); end
    checks++; if (mem_addr !== 8'h40 || ch1_in_addr !== 8'h40) begin errors++; $display("FAIL miss_addr: got %h/%h expected 40/40", mem_addr, ch1_in_addr); end
    checks++; if (fc != 2) begin errors++; $display("FAIL miss_fill_cycles: got %0d expected 2", fc); end
    checks++; if (fills - f0 != 1) begin errors++; $display("FAIL miss_fills: got %0d expected 1", fills - f0); end
    checks++; if (cl != 0 || ib != 0) begin errors++; $display("FAIL miss_strobes: got clash %0d inval %0d expected 0 0", cl, ib); end
    checks++; if (rsp_data !== 32'hCAFEF00D) begin errors++; $display("FAIL miss_data: got %h expected cafef00d", rsp_data); end
    checks++; if (ch1_write !== 1'b0) begin errors++; $display("FAIL miss_write_in_respond: got %b expected 0", ch1_write); end
    checks++; if (miss_count !== 2'd1 || hit_count !== 2'd1) begin errors++; $display("FAIL miss_counts: got %0d/%0d expected 1/1", hit_count, miss_count); end
    release_rsp();
    run_req(8'h40, 1, 32'h0, lat, fc, mc, cl, ib, to);
    checks++; if (to || lat != 2 || mc != 0) begin errors++; $display("FAIL repeat_hit: got lat %0d memreq %0d expected 2 0", lat, mc); end
    checks++; if (rsp_data !== 32'hCAFEF00D) begin errors++; $display("FAIL repeat_data: got %h expected cafef00d", rsp_data); end
    checks++; if (hit_count !== 2'd2) begin errors++; $display("FAIL repeat_count: got %0d expected 2", hit_count); end
    release_rsp();
  endtask

  task automatic test_eviction;
    int lat, fc, mc, cl, ib, f0; bit to;
    cbit[0] = 1'b1; cbit[1] = 1'b1; ptr = 0;
    f0 = fills;
    run_req(8'h77, 1, 32'h0BADF00D, lat, fc, mc, cl, ib, to);
    checks++; if (to) begin errors++; $display("FAIL evict_timeout: got timeout expected response"); end
    checks++; if (fc < 3) begin errors++; $display("FAIL evict_fill_cycles: got %0d expected >=3", fc); end
    checks++; if (fills - f0 != 1) begin errors++; $display("FAIL evict_fills: got %0d expected 1", fills - f0); end
    checks++; if (cl != 0) begin errors++; $display("FAIL evict_clash: got %0d expected 0", cl); end
    checks++; if (rsp_data !== 32'h0BADF00D) begin errors++; $display("FAIL evict_data: got %h expected 0badf00d", rsp_data); end
    checks++; if (miss_count !== 2'd2) begin errors++; $display("FAIL evict_miss_count: got %0d expected 2", miss_count); end
    release_rsp();
  endtask

  task automatic test_backpressure;
    int lat, fc, mc, cl, ib; bit to;
    run_req(8'h77, 1, 32'h0, lat, fc, mc, cl, ib, to);
    checks++; if (to || lat != 2) begin errors++; $display("FAIL bp_latency: got %0d expected 2", lat); end
    req_valid = 1'b1;
    req_addr  = 8'h55;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h0BADF00D || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid %b data %h ready %b expected 1 0badf00d 0", i, rsp_valid, rsp_data, req_ready);
      end
    end
    req_valid = 1'b0;
    release_rsp();
    checks++; if (req_ready !== 1'b1 || hit_count !== 2'd3) begin errors++; $display("FAIL bp_release: got ready %b hits %0d expected 1 3", req_ready, hit_count); end
  endtask

  task automatic test_reset_in_fetch;
    int n;
    req_valid = 1'b1;
    req_addr  = 8'h99;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!mem_req && n < 10) begin tick(); n++; end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rf_reach_fetch: got mem_req %b expected 1", mem_req); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h12345678;
    tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req !== 1'b0 || ch1_write !== 1'b0) begin
        errors++;
        $display("FAIL rf_idle[%0d]: got valid %b ready %b mreq %b wr %b expected 0 1 0 0", i, rsp_valid, req_ready, mem_req, ch1_write);
      end
      tick();
    end
    checks++; if ({hit_count, miss_count} !== 4'b0 || rsp_data !== 32'h0) begin errors++; $display("FAIL rf_cleared: got counts %b data %h expected 0000 0", {hit_count, miss_count}, rsp_data); end
  endtask

  task automatic test_saturation;
    int lat, fc, mc, cl, ib; bit to;
    for (int i = 0; i < 5; i++) begin
      run_req(8'h77, 1, 32'h0, lat, fc, mc, cl, ib, to);
      checks++; if (to || lat != 2) begin errors++; $display("FAIL sat_hit[%0d]: got lat %0d expected 2", i, lat); end
      release_rsp();
      if (i == 3) begin
        checks++; if (hit_count !== 2'd3) begin errors++; $display("FAIL sat_four: got %0d expected 3", hit_count); end
      end
    end
    checks++; if (hit_count !== 2'd3 || miss_count !== 2'd0) begin errors++; $display("FAIL sat_final: got %0d/%0d expected 3/0", hit_count, miss_count); end
  endtask

  initial begin
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    test_reset();
    test_hit();
    test_miss();
    test_eviction();
    test_backpressure();
    test_reset_in_fetch();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
